// File: rtl/i2c_cmd_sequencer.sv
// Command front-end for the I2C master: buffers host commands in a FIFO, issues them one at a time
// with m_start, retries NACKed or timed-out attempts after a gap, and returns one response per command.
module i2c_cmd_sequencer #(
  parameter int DEPTH        = 4,
  parameter int MAX_RETRY    = 2,
  parameter int RETRY_GAP    = 16,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_data,
  input  logic       cmd_rw,
  output logic       rsp_valid,
  output logic [6:0] rsp_addr,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic       rsp_timeout,
  output logic [1:0] rsp_tries,
  output logic       idle,
  output logic       m_start,
  output logic [6:0] m_addr,
  output logic [7:0] m_data,
  output logic       m_rw,
  input  logic       m_busy,
  input  logic       m_ack_error,
  input  logic [7:0] m_data_out
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2(MAX_RETRY + 2);
  localparam int BW = $clog2(BUSY_TIMEOUT + 1);
  localparam int GW = $clog2(RETRY_GAP + 1);

  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [TW-1:0] TRY_MAX  = TW'(MAX_RETRY);
  localparam logic [BW-1:0] TO_LAST  = BW'(BUSY_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(RETRY_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_CHECK,
    S_RETRY_WAIT
  } state_t;

  state_t state;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic          push;
  logic          pop;
  logic [15:0]   head;

  logic [TW-1:0] tries;
  logic [BW-1:0] timer;
  logic [GW-1:0] gap;
  logic          att_fail;
  logic          att_timeout;
  logic [7:0]    att_data;
  logic          retry_now;
  logic          fsm_idle_nxt;
  logic [1:0]    tries_sat;

  assign push = cmd_valid && cmd_ready;
  assign pop  = (state == S_IDLE) && (count != '0);
  assign head = mem[rd_ptr];

  assign retry_now    = att_fail && (tries < TRY_MAX);
  // The FSM lands in IDLE next cycle either by staying there with nothing to pop,
  // or by finishing a command in CHECK; idle is registered from this look-ahead.
  assign fsm_idle_nxt = ((state == S_IDLE) && (count == '0)) ||
                        ((state == S_CHECK) && !retry_now);

  always_comb begin
    tries_sat = 2'(tries);
    if (32'(tries) > 3) tries_sat = 2'd3;
  end

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + 1'b1;
    else if (!push && pop) count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_rw, cmd_addr, cmd_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cmd_ready <= 1'b1;
      idle      <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count     <= count_nxt;
      cmd_ready <= (count_nxt != FULL_CNT);
      idle      <= (count_nxt == '0) && fsm_idle_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      m_start     <= 1'b0;
      m_addr      <= '0;
      m_data      <= '0;
      m_rw        <= 1'b0;
      tries       <= '0;
      timer       <= '0;
      gap         <= '0;
      att_fail    <= 1'b0;
      att_timeout <= 1'b0;
      att_data    <= '0;
      rsp_valid   <= 1'b0;
      rsp_addr    <= '0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_tries   <= '0;
    end else begin
      m_start   <= 1'b0;
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (count != '0) begin
            m_rw   <= head[15];
            m_addr <= head[14:8];
            m_data <= head[7:0];
            tries  <= '0;
            state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          m_start <= 1'b1;
          timer   <= '0;
          state   <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (m_busy) begin
            state <= S_WAIT_DONE;
          end else if (timer == TO_LAST) begin
            att_fail    <= 1'b1;
            att_timeout <= 1'b1;
            att_data    <= '0;
            state       <= S_CHECK;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (!m_busy) begin
            att_fail    <= m_ack_error;
            att_timeout <= 1'b0;
            att_data    <= m_data_out;
            state       <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (retry_now) begin
            tries <= tries + 1'b1;
            gap   <= '0;
            state <= S_RETRY_WAIT;
          end else begin
            rsp_valid   <= 1'b1;
            rsp_addr    <= m_addr;
            rsp_data    <= (m_rw && !att_fail) ? att_data : 8'h00;
            rsp_err     <= att_fail;
            rsp_timeout <= att_fail && att_timeout;
            rsp_tries   <= tries_sat;
            state       <= S_IDLE;
          end
        end
        S_RETRY_WAIT: begin
          if (gap == GAP_LAST) state <= S_ISSUE;
          else                 gap   <= gap + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed bench for i2c_cmd_sequencer: a table of single-command vectors against a small
// I2C master model, plus hand sequences for start latency, retry spacing, FIFO full and reset.
module tb_i2c_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [6:0] cmd_addr = '0;
  logic [7:0] cmd_data = '0;
  logic       cmd_rw = 1'b0;
  logic       rsp_valid;
  logic [6:0] rsp_addr;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       rsp_timeout;
  logic [1:0] rsp_tries;
  logic       idle;
  logic       m_start;
  logic [6:0] m_addr;
  logic [7:0] m_data;
  logic       m_rw;
  logic       m_busy = 1'b0;
  logic       m_ack_error = 1'b0;
  logic [7:0] m_data_out = '0;

  i2c_cmd_sequencer #(.DEPTH(4), .MAX_RETRY(2), .RETRY_GAP(16), .BUSY_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_rw(cmd_rw),
    .rsp_valid(rsp_valid), .rsp_addr(rsp_addr), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout), .rsp_tries(rsp_tries), .idle(idle),
    .m_start(m_start), .m_addr(m_addr), .m_data(m_data), .m_rw(m_rw),
    .m_busy(m_busy), .m_ack_error(m_ack_error), .m_data_out(m_data_out)
  );

  always #5 clk = ~clk;

  // master model configuration, written only by the stimulus process
  int         cfg_busy_len = 10;
  int         cfg_nacks = 0;
  logic       cfg_no_busy = 1'b0;
  logic       cfg_hold = 1'b0;
  logic [7:0] cfg_mdata = 8'h00;
  int         start_base = 0;

  // model / monitor state, written only by the always block below
  int         cyc = 0;
  int         start_cnt = 0;
  int         last_start_cyc = 0;
  int         prev_start_cyc = 0;
  int         rsp_cnt = 0;
  int         busy_left = 0;
  logic       cur_nack = 1'b0;
  logic [6:0] log_addr [64];
  logic [6:0] r_addr = '0;
  logic [7:0] r_data = '0;
  logic       r_err = 1'b0;
  logic       r_to = 1'b0;
  logic [1:0] r_tries = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (m_start) begin
      start_cnt      <= start_cnt + 1;
      prev_start_cyc <= last_start_cyc;
      last_start_cyc <= cyc;
    end
    if (rsp_valid) begin
      log_addr[rsp_cnt[5:0]] <= rsp_addr;
      rsp_cnt <= rsp_cnt + 1;
      r_addr  <= rsp_addr;
      r_data  <= rsp_data;
      r_err   <= rsp_err;
      r_to    <= rsp_timeout;
      r_tries <= rsp_tries;
    end
    if (rst) begin
      m_busy    <= 1'b0;
      busy_left <= 0;
    end else if (m_start && !cfg_no_busy) begin
      m_busy    <= 1'b1;
      busy_left <= cfg_busy_len;
      cur_nack  <= (start_cnt - start_base) < cfg_nacks;
    end else if (m_busy && !cfg_hold) begin
      if (busy_left <= 1) begin
        m_busy      <= 1'b0;
        m_ack_error <= cur_nack;
        m_data_out  <= cfg_mdata;
      end else begin
        busy_left <= busy_left - 1;
      end
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // called at a negedge; returns at the following negedge with cmd_valid dropped
  task automatic push(input logic [6:0] a, input logic [7:0] d, input logic r, output logic acc);
    cmd_valid = 1'b1; cmd_addr = a; cmd_data = d; cmd_rw = r;
    acc = cmd_ready;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsps(input int target, input int budget, input string name);
    int k = 0;
    while (rsp_cnt < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, rsp_cnt, target);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_addr"}, rsp_addr, 0);
    check({tag, "_rsp_data"}, rsp_data, 0);
    check({tag, "_rsp_err"}, rsp_err, 0);
    check({tag, "_rsp_timeout"}, rsp_timeout, 0);
    check({tag, "_rsp_tries"}, rsp_tries, 0);
    check({tag, "_idle"}, idle, 1);
    check({tag, "_m_start"}, m_start, 0);
    check({tag, "_m_addr"}, m_addr, 0);
    check({tag, "_m_data"}, m_data, 0);
    check({tag, "_m_rw"}, m_rw, 0);
  endtask

  typedef struct {
    logic [6:0] addr;
    logic [7:0] data;
    logic       rw;
    int         busy_len;
    int         nacks;
    logic       no_busy;
    logic [7:0] mdata;
    logic       exp_err;
    logic       exp_to;
    logic [1:0] exp_tries;
    logic [7:0] exp_data;
    int         exp_starts;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic acc;
    logic acc_v[6];
    int   base;
    int   sbase;

    // addr data rw busy nacks no_busy mdata | err to tries data starts
    vecs[0] = '{7'h50, 8'hA5, 1'b0, 10, 0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00, 1};
    vecs[1] = '{7'h68, 8'h00, 1'b1, 10, 0, 1'b0, 8'h3C, 1'b0, 1'b0, 2'd0, 8'h3C, 1};
    vecs[2] = '{7'h22, 8'h11, 1'b0, 10, 1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd1, 8'h00, 2};
    vecs[3] = '{7'h33, 8'h44, 1'b0,  6, 5, 1'b0, 8'h00, 1'b1, 1'b0, 2'd2, 8'h00, 3};
    vecs[4] = '{7'h44, 8'h55, 1'b0,  6, 0, 1'b1, 8'h00, 1'b1, 1'b1, 2'd2, 8'h00, 3};
    vecs[5] = '{7'h7F, 8'h00, 1'b1,  4, 1, 1'b0, 8'h5A, 1'b0, 1'b0, 2'd1, 8'h5A, 2};
    vecs[6] = '{7'h01, 8'hFF, 1'b0,  3, 0, 1'b0, 8'h99, 1'b0, 1'b0, 2'd0, 8'h00, 1};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst0");
    rst = 1'b0;
    @(negedge clk);
    check("rst0_post_idle", idle, 1);

    // start latency: push sampled at edge E0, m_start high in the cycle after E2
    cfg_busy_len = 5; cfg_nacks = 0; cfg_no_busy = 1'b0; cfg_mdata = 8'h00;
    start_base = start_cnt;
    base = rsp_cnt;
    push(7'h12, 8'hC3, 1'b1, acc);
    check("lat_acc", acc, 1);
    check("lat_cyc0_start", m_start, 0);
    check("lat_cyc0_idle", idle, 0);
    @(negedge clk);
    check("lat_cyc1_start", m_start, 0);
    @(negedge clk);
    check("lat_cyc2_start", m_start, 1);
    check("lat_m_addr", m_addr, 7'h12);
    check("lat_m_data", m_data, 8'hC3);
    check("lat_m_rw", m_rw, 1);
    @(negedge clk);
    check("lat_cyc3_start", m_start, 0);
    wait_rsps(base + 1, 100, "lat_rsp_cnt");

    for (int i = 0; i < 7; i++) begin
      cfg_busy_len = vecs[i].busy_len;
      cfg_nacks    = vecs[i].nacks;
      cfg_no_busy  = vecs[i].no_busy;
      cfg_mdata    = vecs[i].mdata;
      start_base   = start_cnt;
      base         = rsp_cnt;
      push(vecs[i].addr, vecs[i].data, vecs[i].rw, acc);
      check($sformatf("v%0d_acc", i), acc, 1);
      wait_rsps(base + 1, 400, $sformatf("v%0d_rsp_wait", i));
      check($sformatf("v%0d_idle", i), idle, 1);
      repeat (3) @(negedge clk);
      check($sformatf("v%0d_rsp_cnt", i), rsp_cnt, base + 1);
      check($sformatf("v%0d_addr", i), r_addr, vecs[i].addr);
      check($sformatf("v%0d_data", i), r_data, vecs[i].exp_data);
      check($sformatf("v%0d_err", i), r_err, vecs[i].exp_err);
      check($sformatf("v%0d_timeout", i), r_to, vecs[i].exp_to);
      check($sformatf("v%0d_tries", i), r_tries, vecs[i].exp_tries);
      check($sformatf("v%0d_starts", i), start_cnt - start_base, vecs[i].exp_starts);
      check($sformatf("v%0d_hold_addr", i), rsp_addr, vecs[i].addr);
    end
    cfg_no_busy = 1'b0;

    // retry spacing: busy high 10 cycles, 1 cycle to see busy fall, CHECK, 16 gap cycles,
    // ISSUE, then m_start: 10 + 16 + 4 = 30 cycles between the two starts
    cfg_busy_len = 10; cfg_nacks = 1; cfg_mdata = 8'h00;
    start_base = start_cnt;
    base = rsp_cnt;
    push(7'h2A, 8'h77, 1'b0, acc);
    wait_rsps(base + 1, 400, "gap_rsp_wait");
    check("gap_starts", start_cnt - start_base, 2);
    check("gap_spacing", last_start_cyc - prev_start_cyc, 30);
    check("gap_err", r_err, 0);
    check("gap_tries", r_tries, 1);

    // FIFO full with the master stalled: A is popped, B..E fill the FIFO, F is refused
    cfg_busy_len = 3; cfg_nacks = 0; cfg_hold = 1'b1;
    start_base = start_cnt;
    base = rsp_cnt;
    for (int i = 0; i < 6; i++) begin
      push(7'(8'h10 + i), 8'(i), 1'b0, acc);
      acc_v[i] = acc;
      if (i < 5) cmd_valid = 1'b1;
    end
    for (int i = 0; i < 6; i++) check($sformatf("full_acc%0d", i), acc_v[i], (i < 5) ? 1 : 0);
    check("full_ready_low", cmd_ready, 0);
    check("full_idle_low", idle, 0);
    repeat (10) @(negedge clk);
    check("full_stall_starts", start_cnt - start_base, 1);
    check("full_stall_rsps", rsp_cnt, base);
    cfg_hold = 1'b0;
    wait_rsps(base + 5, 600, "full_rsp_wait");
    repeat (20) @(negedge clk);
    check("full_rsp_total", rsp_cnt, base + 5);
    for (int i = 0; i < 5; i++) check($sformatf("full_order%0d", i), log_addr[(base + i) % 64], 7'(8'h10 + i));
    check("full_idle_end", idle, 1);
    check("full_ready_end", cmd_ready, 1);

    // reset while WAIT_DONE: in-flight command dropped, no response afterwards
    cfg_busy_len = 5; cfg_hold = 1'b1;
    start_base = start_cnt;
    base = rsp_cnt;
    push(7'h5C, 8'h3E, 1'b1, acc);
    begin
      int k = 0;
      while (!m_busy && k < 50) begin
        @(negedge clk);
        k++;
      end
    end
    check("rst1_busy_seen", m_busy, 1);
    repeat (2) @(negedge clk);
    check("rst1_pre_m_addr", m_addr, 7'h5C);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst1_async");
    @(negedge clk);
    rst = 1'b0;
    cfg_hold = 1'b0;
    sbase = start_cnt;
    repeat (40) @(negedge clk);
    check_reset_outputs("rst1_after");
    check("rst1_no_rsp", rsp_cnt, base);
    check("rst1_no_start", start_cnt, sbase);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
